// File: rtl/instruction_loader.sv
// Instruction loader: receives a program as a byte stream from a host link, packs the bytes
// big-endian into instruction words and writes them into instruction memory while holding
// the CPU fetch stage. A word of all ones ends the program. Loading past the last memory
// slot without seeing the marker ends the load with an error.
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to expect one extra byte after the
// marker that must equal the XOR of every byte of the load.
module instruction_loader #(
  parameter int unsigned NB_INSTR           = 32,
  parameter int unsigned NB_BYTE            = 8,
  parameter int unsigned N_ADDR             = 2048,
  parameter int unsigned LOG2_N_INSMEM_ADDR = 11
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [NB_BYTE-1:0]          i_byte,
  input  logic                        i_byte_valid,
  output logic                        o_byte_ready,
  output logic [31:0]                 o_mem_addr,
  output logic [NB_INSTR-1:0]         o_mem_data,
  output logic                        o_mem_wr_en,
  output logic                        o_cpu_hold,
  output logic                        o_done,
  output logic                        o_error,
  output logic [LOG2_N_INSMEM_ADDR:0] o_word_count
);

  localparam int unsigned BytesPerWord = NB_INSTR / NB_BYTE;
  localparam int unsigned ByteCntW     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
  localparam int unsigned CntW         = LOG2_N_INSMEM_ADDR + 1;
  localparam logic [ByteCntW-1:0] LastByte = ByteCntW'(BytesPerWord - 1);
  localparam logic [CntW-1:0]     LastSlot = CntW'(N_ADDR - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_e;

  state_e state_q, state_d;

  logic [ByteCntW-1:0] byte_cnt_q;
  logic [NB_INSTR-1:0] partial_q;
  logic [CntW-1:0]     word_count_q;
  logic [31:0]         mem_addr_q;
  logic [NB_INSTR-1:0] mem_data_q;
  logic                mem_wr_en_q;
  logic                error_q;

  logic                start_load;
  logic                accept;
  logic                load_accept;
  logic                check_accept;
  logic                word_done;
  logic                is_marker;
  logic                is_last_slot;
  logic                checksum_bad;
  logic [NB_INSTR-1:0] word_next;

  assign start_load   = i_start && ((state_q == StIdle) || (state_q == StDone));
  assign accept       = i_byte_valid && o_byte_ready;
  assign load_accept  = accept && (state_q == StLoad);
  assign check_accept = accept && (state_q == StCheck);
  assign word_next    = {partial_q[NB_INSTR-NB_BYTE-1:0], i_byte};
  assign word_done    = load_accept && (byte_cnt_q == LastByte);
  assign is_marker    = (word_next == {NB_INSTR{1'b1}});
  assign is_last_slot = (word_count_q == LastSlot);

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_e MarkerNext = StCheck;

  logic [NB_BYTE-1:0] checksum_q;

  // Running XOR of every byte accepted in LOAD, marker bytes included.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      checksum_q <= '0;
    end else if (start_load) begin
      checksum_q <= '0;
    end else if (load_accept) begin
      checksum_q <= checksum_q ^ i_byte;
    end
  end

  assign checksum_bad = (i_byte != checksum_q);
`else
  localparam state_e MarkerNext = StDone;

  assign checksum_bad = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; i_start is only honoured from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) state_d = StLoad;
      end
      StLoad: begin
        if (word_done) begin
          if (is_marker) begin
            state_d = MarkerNext;
          end else if (is_last_slot) begin
            state_d = StDone;
          end
        end
      end
      StCheck: begin
        if (check_accept) state_d = StDone;
      end
      StDone: begin
        if (i_start) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs; the CPU is released only after a clean load.
  always_comb begin
    o_byte_ready = 1'b0;
    o_done       = 1'b0;
    o_cpu_hold   = 1'b1;
    unique case (state_q)
      StLoad, StCheck: o_byte_ready = 1'b1;
      StDone: begin
        o_done     = 1'b1;
        o_cpu_hold = error_q;
      end
      default: ;
    endcase
  end

  // Byte packing, memory write port and status flags.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      byte_cnt_q   <= '0;
      partial_q    <= '0;
      word_count_q <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_wr_en_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      mem_wr_en_q <= 1'b0;
      if (start_load) begin
        byte_cnt_q   <= '0;
        partial_q    <= '0;
        word_count_q <= '0;
        error_q      <= 1'b0;
      end else if (load_accept) begin
        partial_q  <= word_next;
        byte_cnt_q <= (byte_cnt_q == LastByte) ? '0 : byte_cnt_q + 1'b1;
        if (word_done) begin
          mem_wr_en_q  <= 1'b1;
          mem_data_q   <= word_next;
          mem_addr_q   <= 32'(word_count_q) * BytesPerWord;
          word_count_q <= word_count_q + 1'b1;
          // Memory full without a marker: the program does not fit.
          if (!is_marker && is_last_slot) error_q <= 1'b1;
        end
      end else if (check_accept) begin
        error_q <= checksum_bad;
      end
    end
  end

  assign o_mem_addr   = mem_addr_q;
  assign o_mem_data   = mem_data_q;
  assign o_mem_wr_en  = mem_wr_en_q;
  assign o_error      = error_q;
  assign o_word_count = word_count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader. A default-size instance carries the main
// tests; a 4-word instance sharing the same stimulus exercises memory overflow.
// Define INSTR_LOADER_CHECKSUM_EN for both files to test the checksum build.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        valid;

  logic        ready, wr, hold, done, err;
  logic [31:0] addr, data;
  logic [11:0] wc;

  logic        s_ready, s_wr, s_hold, s_done, s_err;
  logic [31:0] s_addr, s_data;
  logic [2:0]  s_wc;

  logic [7:0]  stim[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic [31:0] cap_addr[$], cap_data[$];
  logic [31:0] cap_s_addr[$], cap_s_data[$];
  logic [31:0] sav_addr[$], sav_data[$];
  bit          exp_err;
  int          exp_words;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  instruction_loader dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_byte       (byte_in),
    .i_byte_valid (valid),
    .o_byte_ready (ready),
    .o_mem_addr   (addr),
    .o_mem_data   (data),
    .o_mem_wr_en  (wr),
    .o_cpu_hold   (hold),
    .o_done       (done),
    .o_error      (err),
    .o_word_count (wc)
  );

  instruction_loader #(
    .NB_INSTR           (32),
    .NB_BYTE            (8),
    .N_ADDR             (4),
    .LOG2_N_INSMEM_ADDR (2)
  ) dut_small (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_byte       (byte_in),
    .i_byte_valid (valid),
    .o_byte_ready (s_ready),
    .o_mem_addr   (s_addr),
    .o_mem_data   (s_data),
    .o_mem_wr_en  (s_wr),
    .o_cpu_hold   (s_hold),
    .o_done       (s_done),
    .o_error      (s_err),
    .o_word_count (s_wc)
  );

  // Write monitor: every strobe lasts one cycle, so one negedge sees it.
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      cap_addr.push_back(addr);
      cap_data.push_back(data);
    end
    if (s_wr === 1'b1) begin
      cap_s_addr.push_back(s_addr);
      cap_s_data.push_back(s_data);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    byte_in = b;
    valid   = 1'b1;
    n       = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: ready=%b required 1", ready);
    end
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic push_stream(input bit gappy);
    foreach (stim[j]) begin
      push_byte(stim[j]);
      if (gappy) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  // Random program of nwords non-marker words followed by the marker (and checksum).
  task automatic gen_program(input int nwords);
    logic [31:0] w;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    stim.delete();
    for (int k = 0; k <= nwords; k++) begin
      w = (k == nwords) ? 32'hFFFF_FFFF : $urandom;
      if (k < nwords && w == 32'hFFFF_FFFF) w = 32'h0;
      for (int b = 3; b >= 0; b--) stim.push_back(w[b*8 +: 8]);
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    foreach (stim[j]) x ^= stim[j];
    stim.push_back(x);
`endif
  endtask

  // Reference: chop the byte list into big-endian words until marker or memory full.
  task automatic build_model(input int n_addr);
    logic [31:0] w;
    int i, words;
    bit fin;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    exp_addr.delete(); exp_data.delete();
    exp_err = 1'b0; i = 0; words = 0; fin = 1'b0;
    while (!fin && i + 3 < stim.size()) begin
      w = {stim[i], stim[i+1], stim[i+2], stim[i+3]};
`ifdef INSTR_LOADER_CHECKSUM_EN
      x = x ^ stim[i] ^ stim[i+1] ^ stim[i+2] ^ stim[i+3];
`endif
      exp_addr.push_back(32'(4 * words));
      exp_data.push_back(w);
      words++;
      i += 4;
      if (w == 32'hFFFF_FFFF) begin
        fin = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
        exp_err = (i >= stim.size()) || (stim[i] != x);
`endif
      end else if (words == n_addr) begin
        fin = 1'b1;
        exp_err = 1'b1;
      end
    end
    exp_words = words;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; valid = 1'b1; byte_in = 8'hAA;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", ready); end
    n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", wr); end
    n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", addr); end
    n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", data); end
    n_checks++; if (hold !== 1'b1) begin n_fail++; $display("FAIL rst_hold: got %b want 1", hold); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b want 0", err); end
    n_checks++; if (wc !== 12'd0) begin n_fail++; $display("FAIL rst_wc: got %0d want 0", wc); end
    rst = 1'b0; start = 1'b0; valid = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_idle_ready: got %b want 0", ready); end
  endtask

  task automatic test_directed();
    cap_addr.delete(); cap_data.delete();
    stim = {8'h20, 8'h10, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifdef INSTR_LOADER_CHECKSUM_EN
    stim.push_back(8'h35);
`endif
    pulse_start();
    push_stream(1'b0);
    settle();
    n_checks++;
    if (cap_addr.size() != 2) begin
      n_fail++; $display("FAIL dir_nwrites: got %0d want 2", cap_addr.size());
    end else begin
      n_checks++; if (cap_addr[0] !== 32'h0 || cap_data[0] !== 32'h2010_0005) begin
        n_fail++; $display("FAIL dir_w0: got %h/%h want 00000000/20100005", cap_addr[0], cap_data[0]);
      end
      n_checks++; if (cap_addr[1] !== 32'h4 || cap_data[1] !== 32'hFFFF_FFFF) begin
        n_fail++; $display("FAIL dir_w1: got %h/%h want 00000004/ffffffff", cap_addr[1], cap_data[1]);
      end
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL dir_done: got %b want 1", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL dir_error: got %b want 0", err); end
    n_checks++; if (hold !== 1'b0) begin n_fail++; $display("FAIL dir_hold: got %b want 0", hold); end
    n_checks++; if (wc !== 12'd2) begin n_fail++; $display("FAIL dir_wc: got %0d want 2", wc); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL dir_ready: got %b want 0", ready); end
  endtask

  // Each load restarts from DONE, so this also covers restart addressing.
  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      gen_program($urandom_range(1, 6));
`ifdef INSTR_LOADER_CHECKSUM_EN
      if (it[0]) stim[stim.size()-1] = stim[stim.size()-1] ^ 8'($urandom_range(1, 255));
`endif
      build_model(2048);
      cap_addr.delete(); cap_data.delete();
      pulse_start();
      push_stream(1'b0);
      settle();
      n_checks++;
      if (cap_addr.size() != exp_addr.size()) begin
        n_fail++; $display("FAIL rnd_nwrites: got %0d want %0d", cap_addr.size(), exp_addr.size());
      end else begin
        foreach (exp_addr[j]) begin
          n_checks++;
          if (cap_addr[j] !== exp_addr[j] || cap_data[j] !== exp_data[j]) begin
            n_fail++;
            $display("FAIL rnd_write%0d: got %h/%h want %h/%h", j, cap_addr[j], cap_data[j],
                     exp_addr[j], exp_data[j]);
          end
        end
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rnd_done: got %b want 1", done); end
      n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL rnd_error: got %b want %b", err, exp_err); end
      n_checks++; if (hold !== exp_err) begin n_fail++; $display("FAIL rnd_hold: got %b want %b", hold, exp_err); end
      n_checks++; if (wc !== 12'(exp_words)) begin n_fail++; $display("FAIL rnd_wc: got %0d want %0d", wc, exp_words); end
    end
  endtask

  task automatic test_gappy();
    gen_program(3);
    build_model(2048);
    cap_addr.delete(); cap_data.delete();
    pulse_start();
    push_stream(1'b0);
    settle();
    sav_addr = cap_addr; sav_data = cap_data;
    cap_addr.delete(); cap_data.delete();
    pulse_start();
    push_stream(1'b1);
    settle();
    n_checks++;
    if (cap_addr.size() != sav_addr.size() || cap_addr.size() != exp_addr.size()) begin
      n_fail++; $display("FAIL gap_nwrites: got %0d want %0d", cap_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[j]) begin
        n_checks++;
        if (cap_addr[j] !== sav_addr[j] || cap_data[j] !== sav_data[j] ||
            cap_data[j] !== exp_data[j] || cap_addr[j] !== exp_addr[j]) begin
          n_fail++;
          $display("FAIL gap_write%0d: got %h/%h want %h/%h", j, cap_addr[j], cap_data[j],
                   exp_addr[j], exp_data[j]);
        end
      end
    end
    n_checks++; if (wc !== 12'(exp_words)) begin n_fail++; $display("FAIL gap_wc: got %0d want %0d", wc, exp_words); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL gap_done: got %b want 1", done); end
  endtask

  task automatic test_start_ignored();
    do_reset();
    gen_program(2);
    build_model(2048);
    cap_addr.delete(); cap_data.delete();
    pulse_start();
    for (int j = 0; j < 4; j++) push_byte(stim[j]);
    pulse_start();
    for (int j = 4; j < stim.size(); j++) push_byte(stim[j]);
    settle();
    n_checks++;
    if (cap_addr.size() != exp_addr.size()) begin
      n_fail++; $display("FAIL ign_nwrites: got %0d want %0d", cap_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[j]) begin
        n_checks++;
        if (cap_addr[j] !== exp_addr[j] || cap_data[j] !== exp_data[j]) begin
          n_fail++;
          $display("FAIL ign_write%0d: got %h/%h want %h/%h", j, cap_addr[j], cap_data[j],
                   exp_addr[j], exp_data[j]);
        end
      end
    end
    pulse_start();
    #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL restart_done: got %b want 0", done); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL restart_ready: got %b want 1", ready); end
    n_checks++; if (wc !== 12'd0) begin n_fail++; $display("FAIL restart_wc: got %0d want 0", wc); end
    cap_addr.delete(); cap_data.delete();
    stim = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifdef INSTR_LOADER_CHECKSUM_EN
    stim.push_back(8'h00);
`endif
    push_stream(1'b0);
    settle();
    n_checks++;
    if (cap_addr.size() != 1) begin
      n_fail++; $display("FAIL restart_nwrites: got %0d want 1", cap_addr.size());
    end else if (cap_addr[0] !== 32'h0 || cap_data[0] !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL restart_w0: got %h/%h want 00000000/ffffffff", cap_addr[0], cap_data[0]);
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL restart_done2: got %b want 1", done); end
  endtask

  task automatic test_overflow();
    do_reset();
    stim.delete();
    for (int j = 0; j < 16; j++) stim.push_back(8'($urandom_range(0, 254)));
    build_model(4);
    cap_s_addr.delete(); cap_s_data.delete();
    pulse_start();
    push_stream(1'b0);
    settle();
    n_checks++;
    if (cap_s_addr.size() != 4) begin
      n_fail++; $display("FAIL ovf_nwrites: got %0d want 4", cap_s_addr.size());
    end else begin
      foreach (exp_addr[j]) begin
        n_checks++;
        if (cap_s_addr[j] !== exp_addr[j] || cap_s_data[j] !== exp_data[j]) begin
          n_fail++;
          $display("FAIL ovf_write%0d: got %h/%h want %h/%h", j, cap_s_addr[j], cap_s_data[j],
                   exp_addr[j], exp_data[j]);
        end
      end
      n_checks++; if (cap_s_addr[3] !== 32'hC) begin n_fail++; $display("FAIL ovf_last_addr: got %h want 0000000c", cap_s_addr[3]); end
    end
    n_checks++; if (s_err !== 1'b1) begin n_fail++; $display("FAIL ovf_error: got %b want 1", s_err); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready: got %b want 0", s_ready); end
    n_checks++; if (s_hold !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %b want 1", s_hold); end
    n_checks++; if (s_done !== 1'b1) begin n_fail++; $display("FAIL ovf_done: got %b want 1", s_done); end
    n_checks++; if (s_wc !== 3'd4) begin n_fail++; $display("FAIL ovf_wc: got %0d want 4", s_wc); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    stim.delete();
    for (int j = 0; j < 6; j++) stim.push_back(8'($urandom_range(0, 254)));
    build_model(2048);
    cap_addr.delete(); cap_data.delete();
    pulse_start();
    push_stream(1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL mid_wr_en: got %b want 0", wr); end
    rst = 1'b0;
    settle();
    n_checks++;
    if (cap_addr.size() != 1) begin
      n_fail++; $display("FAIL mid_nwrites: got %0d want 1", cap_addr.size());
    end else if (cap_addr[0] !== 32'h0 || cap_data[0] !== exp_data[0]) begin
      n_fail++; $display("FAIL mid_w0: got %h/%h want 00000000/%h", cap_addr[0], cap_data[0], exp_data[0]);
    end
    n_checks++; if (wc !== 12'd0) begin n_fail++; $display("FAIL mid_wc: got %0d want 0", wc); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", ready); end
    n_checks++; if (done !== 1'b0 || hold !== 1'b1) begin
      n_fail++; $display("FAIL mid_idle: got done=%b hold=%b want done=0 hold=1", done, hold);
    end
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    do_reset();
    stim = {8'h20, 8'h10, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    cap_addr.delete(); cap_data.delete();
    pulse_start();
    push_stream(1'b0);
    settle();
    n_checks++; if (cap_addr.size() != 2) begin n_fail++; $display("FAIL chk_nwrites: got %0d want 2", cap_addr.size()); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL chk_done: got %b want 1", done); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL chk_error: got %b want 1", err); end
    n_checks++; if (hold !== 1'b1) begin n_fail++; $display("FAIL chk_hold: got %b want 1", hold); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; byte_in = 8'h00;
    test_reset();
    test_directed();
    test_random();
    test_gappy();
    test_start_ignored();
    test_overflow();
    test_reset_mid_load();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
